// File: rtl/uart_program_loader.sv
`default_nettype none
// ============================================================================
// Module   : uart_program_loader
// Purpose  : Parses a length-prefixed program image arriving byte-by-byte
//            from a UART receiver, writes it into instruction memory as
//            32-bit little-endian words, holds the core in reset until the
//            image is complete, then answers with an ack (or nak) byte.
// Ports    : clk, rstn            - clock, asynchronous active-low reset
//            rx_data/valid/ferr   - received byte strobe and framing error
//            tx_busy              - transmitter busy (tx_start gated by it)
//            tx_data/tx_start     - one-cycle transmit request and its byte
//            imem_we/addr/wdata   - one-cycle instruction-memory write
//            core_rstn            - core reset, released only once loaded
//            load_done/load_err   - terminal status flags
//            word_count           - header value N as received
// Revision : 1.0 - initial release
// ============================================================================
module uart_program_loader #(
    parameter int          IMEM_DEPTH = 32,
    parameter int          ADDR_W     = 5,
    parameter logic [7:0]  ACK_BYTE   = 8'hAA,
    parameter logic [7:0]  NAK_BYTE   = 8'hEE
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic [7:0]        rx_data,
    input  logic              rx_valid,
    input  logic              rx_ferr,
    input  logic              tx_busy,
    output logic [7:0]        tx_data,
    output logic              tx_start,
    output logic              imem_we,
    output logic [ADDR_W-1:0] imem_addr,
    output logic [31:0]       imem_wdata,
    output logic              core_rstn,
    output logic              load_done,
    output logic              load_err,
    output logic [31:0]       word_count
);

    // Loader states. NAK is the "error, nak not yet sent" phase; ERR is the
    // terminal error state reached once the nak has gone out.
    localparam logic [2:0] c_st_hdr  = 3'd0;
    localparam logic [2:0] c_st_data = 3'd1;
    localparam logic [2:0] c_st_ack  = 3'd2;
    localparam logic [2:0] c_st_done = 3'd3;
    localparam logic [2:0] c_st_nak  = 3'd4;
    localparam logic [2:0] c_st_err  = 3'd5;

    localparam logic [31:0] c_depth = 32'(IMEM_DEPTH);

    logic [2:0]        r_state;
    logic [1:0]        r_byte_idx;
    logic [ADDR_W-1:0] r_word_idx;
    logic [23:0]       r_shift;      // bytes 0..2 of the word being assembled
    logic [7:0]        r_tx_data;
    logic              r_tx_start;
    logic              r_imem_we;
    logic [ADDR_W-1:0] r_imem_addr;
    logic [31:0]       r_imem_wdata;
    logic              r_core_rstn;
    logic              r_load_done;
    logic              r_load_err;
    logic [31:0]       r_word_count;

    logic              w_rx_active;
    logic              w_ferr;
    logic              w_rx_ok;
    logic              w_word_end;
    logic [31:0]       w_word;
    logic              w_last_word;
    logic              w_bad_hdr;

    // Bytes only matter while parsing; in ACK/DONE/NAK/ERR they are dropped.
    assign w_rx_active = rx_valid && ((r_state == c_st_hdr) || (r_state == c_st_data));
    assign w_ferr      = w_rx_active && rx_ferr;
    assign w_rx_ok     = w_rx_active && !rx_ferr;
    assign w_word_end  = w_rx_ok && (r_byte_idx == 2'd3);
    // The 4th byte is used directly, so a full word is available on its strobe.
    assign w_word      = {rx_data, r_shift};
    assign w_bad_hdr   = (w_word == 32'd0) || (w_word > c_depth);
    assign w_last_word = ({{(32-ADDR_W){1'b0}}, r_word_idx} == (r_word_count - 32'd1));

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state      <= c_st_hdr;
            r_byte_idx   <= 2'd0;
            r_word_idx   <= '0;
            r_shift      <= 24'd0;
            r_tx_data    <= 8'd0;
            r_tx_start   <= 1'b0;
            r_imem_we    <= 1'b0;
            r_imem_addr  <= '0;
            r_imem_wdata <= 32'd0;
            r_core_rstn  <= 1'b0;
            r_load_done  <= 1'b0;
            r_load_err   <= 1'b0;
            r_word_count <= 32'd0;
        end else begin
            r_tx_start <= 1'b0;
            r_imem_we  <= 1'b0;

            if (w_rx_ok) begin
                r_byte_idx <= r_byte_idx + 2'd1;
                case (r_byte_idx)
                    2'd0:    r_shift[7:0]   <= rx_data;
                    2'd1:    r_shift[15:8]  <= rx_data;
                    2'd2:    r_shift[23:16] <= rx_data;
                    default: ;
                endcase
            end

            case (r_state)
                c_st_hdr: begin
                    if (w_ferr) begin
                        r_state <= c_st_nak;
                    end else if (w_word_end) begin
                        r_word_count <= w_word;
                        r_word_idx   <= '0;
                        r_state      <= w_bad_hdr ? c_st_nak : c_st_data;
                    end
                end
                c_st_data: begin
                    if (w_ferr) begin
                        r_state <= c_st_nak;
                    end else if (w_word_end) begin
                        r_imem_we    <= 1'b1;
                        r_imem_addr  <= r_word_idx;
                        r_imem_wdata <= w_word;
                        // Leaving on the last word keeps the index from wrapping
                        // when N equals the full memory depth.
                        if (w_last_word) begin
                            r_state <= c_st_ack;
                        end else begin
                            r_word_idx <= r_word_idx + 1'b1;
                        end
                    end
                end
                c_st_ack: begin
                    if (!tx_busy) begin
                        r_tx_start <= 1'b1;
                        r_tx_data  <= ACK_BYTE;
                        r_state    <= c_st_done;
                    end
                end
                c_st_done: begin
                    r_load_done <= 1'b1;
                    r_core_rstn <= 1'b1;
                end
                c_st_nak: begin
                    if (!tx_busy) begin
                        r_tx_start <= 1'b1;
                        r_tx_data  <= NAK_BYTE;
                        r_state    <= c_st_err;
                    end
                end
                c_st_err: begin
                    r_load_err <= 1'b1;
                end
                default: begin
                    r_state <= c_st_nak;
                end
            endcase
        end
    end

    assign tx_data    = r_tx_data;
    assign tx_start   = r_tx_start;
    assign imem_we    = r_imem_we;
    assign imem_addr  = r_imem_addr;
    assign imem_wdata = r_imem_wdata;
    assign core_rstn  = r_core_rstn;
    assign load_done  = r_load_done;
    assign load_err   = r_load_err;
    assign word_count = r_word_count;

endmodule
`default_nettype wire
